// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from VGA syncs and tracks timing lock
module vga_sync_decoder #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_hsy,
  input  logic        vga_vsy,
  input  logic        vga_red,
  input  logic        vga_green,
  input  logic        vga_blue,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        pix_de,
  output logic [2:0]  pix_rgb,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [10:0] frame_lines,
  output logic        sync_err
);
  localparam logic [10:0] HT   = 11'(H_TOTAL);
  localparam logic [10:0] HA   = 11'(H_ACTIVE);
  localparam logic [10:0] HS   = 11'(H_SYNC_START);
  localparam logic [10:0] VT   = 11'(V_TOTAL);
  localparam logic [10:0] VA   = 11'(V_ACTIVE);
  localparam logic [10:0] VS   = 11'(V_SYNC_START);
  localparam logic [10:0] MISS = 11'(2 * H_TOTAL);
  localparam logic [7:0]  LF   = 8'(LOCK_FRAMES);
  typedef enum logic [1:0] {SEARCH, TRACK, LOCK} state_t;
  state_t      state;
  logic        hs_r, vs_r, hs_p, vs_p, first_h;
  logic [2:0]  rgb_r;
  logic [10:0] h_cnt, v_cnt, p_cnt, l_cnt, h_nxt, v_nxt;
  logic [7:0]  good;
  logic        hs_fall, vs_fall, h_wrap, h_bad, v_bad, m_bad, viol, go_lock;

  assign hs_fall = hs_p & ~hs_r;
  assign vs_fall = vs_p & ~vs_r;
  assign h_wrap  = ~hs_fall & (h_cnt == HT - 11'd1);
  assign h_nxt   = hs_fall ? HS : h_wrap ? 11'd0 : h_cnt + 11'd1;
  assign v_nxt   = vs_fall ? VS : !h_wrap ? v_cnt : (v_cnt == VT - 11'd1) ? 11'd0 : v_cnt + 11'd1;
  // the first hsync after entering TRACK closes a period that started while searching
  assign h_bad   = hs_fall & ~first_h & (p_cnt != HT);
  assign v_bad   = vs_fall & (l_cnt != VT);
  assign m_bad   = ~hs_fall & (p_cnt + 11'd1 == MISS);
  assign viol    = (state != SEARCH) & (h_bad | v_bad | m_bad);
  assign go_lock = ~viol & ((state == LOCK) | ((state == TRACK) & vs_fall & (good + 8'd1 == LF)));
  assign pix_x   = h_cnt;
  assign pix_y   = v_cnt;

  // input capture plus one-sample history for sync edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hs_r  <= 1'b1;
      vs_r  <= 1'b1;
      hs_p  <= 1'b1;
      vs_p  <= 1'b1;
      rgb_r <= '0;
    end else begin
      hs_r  <= vga_hsy;
      vs_r  <= vga_vsy;
      hs_p  <= hs_r;
      vs_p  <= vs_r;
      rgb_r <= {vga_red, vga_green, vga_blue};
    end

  // position counters, period/line measurement and colour pipeline
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      p_cnt       <= '0;
      l_cnt       <= '0;
      line_len    <= '0;
      frame_lines <= '0;
      pix_rgb     <= '0;
    end else begin
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      p_cnt   <= hs_fall ? 11'd1 : (p_cnt == 11'h7ff) ? p_cnt : p_cnt + 11'd1;
      l_cnt   <= vs_fall ? 11'd0 : (hs_fall && l_cnt != 11'h7ff) ? l_cnt + 11'd1 : l_cnt;
      pix_rgb <= rgb_r;
      if (hs_fall) line_len <= p_cnt;
      if (vs_fall) frame_lines <= l_cnt;
    end

  // lock state machine with registered status and display-enable outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= SEARCH;
      good     <= '0;
      first_h  <= 1'b0;
      locked   <= 1'b0;
      sync_err <= 1'b0;
      pix_de   <= 1'b0;
    end else begin
      sync_err <= viol;
      locked   <= go_lock;
      pix_de   <= go_lock & (h_nxt < HA) & (v_nxt < VA);
      if (hs_fall) first_h <= 1'b0;
      if (viol) state <= SEARCH;
      else if (state == SEARCH && vs_fall) begin
        state   <= TRACK;
        good    <= '0;
        first_h <= 1'b1;
      end else if (state == TRACK && vs_fall) begin
        good <= good + 8'd1;
        if (go_lock) state <= LOCK;
      end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: scoreboard bench for vga_sync_decoder at reduced timing
module tb_vga_sync_decoder;
  localparam int HT = 80, HA = 64, HS = 66, VT = 20, VA = 16, VS = 18;
  logic        clk = 0, rst_n = 0;
  logic        vga_hsy = 1, vga_vsy = 1, vga_red = 0, vga_green = 0, vga_blue = 0;
  logic [10:0] pix_x, pix_y, line_len, frame_lines;
  logic [2:0]  pix_rgb;
  logic        pix_de, locked, sync_err;
  typedef struct {int x; int y; int rgb; int de;} pix_t;
  typedef struct {int x; int y; int ll; int fl;} err_t;
  pix_t pix_q[$];
  err_t err_q[$];
  pix_t pm;
  err_t em;
  int   total = 0, bad = 0;
  int   cur_x = 0, cur_y = 0, sx, sy, dx = 0, dy = 0;
  bit   probe_drv = 0, probe_en = 0, lock_exp = 0, sp, dp = 0;

  vga_sync_decoder #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HS),
    .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VS), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vga_hsy(vga_hsy), .vga_vsy(vga_vsy),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de), .pix_rgb(pix_rgb),
    .locked(locked), .line_len(line_len), .frame_lines(frame_lines), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int x, input int y, input bit hs_en);
    logic [2:0] rgb;
    @(negedge clk);
    cur_x = x;
    cur_y = y;
    rgb = (x == 10 && y == 5) ? 3'b101 : 3'(x + y);
    vga_hsy = !(hs_en && x >= HS && x < HS + 10);
    vga_vsy = !(y == VS || y == VS + 1);
    {vga_red, vga_green, vga_blue} = rgb;
    probe_drv = probe_en && ((y == 5 && (x == 10 || x == 63 || x == 64)) || (x == 0 && (y == 15 || y == 16)));
    if (probe_drv) pix_q.push_back('{x, y, int'(rgb), int'(lock_exp && x < HA && y < VA)});
  endtask

  task automatic line(input int y, input int len, input bit hs_en);
    for (int x = 0; x < len; x++) tick(x, y, hs_en);
  endtask

  task automatic frame(input int nl, input int short_y, input int nohs_y);
    for (int y = 0; y < nl; y++) line(y, (y == short_y) ? HT - 1 : HT, y != nohs_y);
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_pix_x"}, int'(pix_x), 0);
    chk({tag, "_pix_y"}, int'(pix_y), 0);
    chk({tag, "_pix_de"}, int'(pix_de), 0);
    chk({tag, "_pix_rgb"}, int'(pix_rgb), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_line_len"}, int'(line_len), 0);
    chk({tag, "_frame_lines"}, int'(frame_lines), 0);
    chk({tag, "_sync_err"}, int'(sync_err), 0);
  endtask

  // monitor: outputs at edge k+1 describe the sample captured at edge k
  initial forever begin
    @(posedge clk);
    sx = cur_x;
    sy = cur_y;
    sp = probe_drv;
    #1;
    if (sync_err) begin
      if (err_q.size() == 0) chk("unexpected_sync_err", 1, 0);
      else begin
        em = err_q.pop_front();
        chk("err_at_x", dx, em.x);
        chk("err_at_y", dy, em.y);
        chk("err_line_len", int'(line_len), em.ll);
        chk("err_frame_lines", int'(frame_lines), em.fl);
        chk("err_locked", int'(locked), 0);
      end
    end
    if (dp) begin
      if (pix_q.size() == 0) chk("pix_q_underflow", 1, 0);
      else begin
        pm = pix_q.pop_front();
        chk("pix_x", int'(pix_x), pm.x);
        chk("pix_y", int'(pix_y), pm.y);
        chk("pix_rgb", int'(pix_rgb), pm.rgb);
        chk("pix_de", int'(pix_de), pm.de);
      end
    end
    dx = sx;
    dy = sy;
    dp = sp;
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_chk("rst");
    rst_n = 1;
    frame(VT, -1, -1);
    chk("lock_f0", int'(locked), 0);
    probe_en = 1;
    lock_exp = 0;
    frame(VT, -1, -1);
    probe_en = 0;
    chk("lock_f1", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_f2", int'(locked), 1);
    chk("line_len_ideal", int'(line_len), HT);
    chk("frame_lines_ideal", int'(frame_lines), VT);
    probe_en = 1;
    lock_exp = 1;
    frame(VT, -1, -1);
    probe_en = 0;
    err_q.push_back('{HS, 9, HT - 1, VT});
    frame(VT, 8, -1);
    chk("lock_after_short", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_relock1", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_relock2", int'(locked), 1);
    err_q.push_back('{HS - 1, 11, HT, VT});
    frame(VT, -1, 10);
    chk("lock_after_nohs", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_nohs_relock1", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_nohs_relock2", int'(locked), 1);
    err_q.push_back('{0, VS, HT, VT - 1});
    frame(VT - 1, -1, -1);
    chk("lock_before_short_frame_edge", int'(locked), 1);
    frame(VT, -1, -1);
    chk("lock_after_short_frame", int'(locked), 0);
    chk("frame_lines_short", int'(frame_lines), VT - 1);
    frame(VT, -1, -1);
    chk("lock_f12", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_f13", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_f14", int'(locked), 1);
    for (int y = 0; y < 5; y++) line(y, HT, 1);
    for (int x = 0; x < 30; x++) tick(x, 5, 1);
    #2 rst_n = 0;
    #1 reset_chk("mid_rst");
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int x = 30; x < HT; x++) tick(x, 5, 1);
    for (int y = 6; y < VS; y++) line(y, HT, 1);
    chk("no_lock_before_vsync", int'(locked), 0);
    for (int y = VS; y < VT; y++) line(y, HT, 1);
    chk("lock_post_rst_track", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_post_rst1", int'(locked), 0);
    frame(VT, -1, -1);
    chk("lock_post_rst2", int'(locked), 1);
    chk("line_len_final", int'(line_len), HT);
    chk("frame_lines_final", int'(frame_lines), VT);
    repeat (3) @(negedge clk);
    chk("err_q_drained", err_q.size(), 0);
    chk("pix_q_drained", pix_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 The block SHALL have parameter H_TOTAL, default 800, meaning clocks per line.
REQ-002 The block SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-003 The block SHALL have parameter H_SYNC_START, default 656, meaning the x value at the hsync falling edge.
REQ-004 The block SHALL have parameter V_TOTAL, default 525, meaning lines per frame.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-006 The block SHALL have parameter V_SYNC_START, default 490, meaning the y value at the vsync falling edge.
REQ-007 The block SHALL have parameter LOCK_FRAMES, default 2, meaning the number of consecutive good frames required to lock.
REQ-008 The block SHALL have port clk, input, width 1: pixel clock; all logic is on the rising edge.
REQ-009 The block SHALL have port rst_n, input, width 1: asynchronous active-low reset.
REQ-010 The block SHALL have ports vga_hsy and vga_vsy, inputs, width 1 each: active-low sync, synchronous to clk.
REQ-011 The block SHALL have ports vga_red, vga_green and vga_blue, inputs, width 1 each: pixel colour.
REQ-012 The block SHALL have port pix_x, output, width 11: recovered column.
REQ-013 The block SHALL have port pix_y, output, width 11: recovered row.
REQ-014 The block SHALL have port pix_de, output, width 1: visible-pixel qualifier.
REQ-015 The block SHALL have port pix_rgb, output, width 3: {red, green, blue}, aligned with pix_x and pix_y.
REQ-016 The block SHALL have port locked, output, width 1: timing matches the parameters.
REQ-017 The block SHALL have port line_len, output, width 11: last measured hsync period in clocks.
REQ-018 The block SHALL have port frame_lines, output, width 11: last measured lines per frame.
REQ-019 The block SHALL have port sync_err, output, width 1: one-clock pulse on a timing violation.

Function
REQ-020 The block SHALL register all five inputs once; hsync and vsync edges are detected on the registered samples (current vs previous).
REQ-021 All outputs SHALL be registered, and pix_x, pix_y, pix_rgb and pix_de SHALL describe the input sample taken 2 clk edges earlier.
REQ-022 On an hsync falling edge, h_cnt SHALL load H_SYNC_START; otherwise it SHALL increment, wrapping from H_TOTAL-1 to 0.
REQ-023 v_cnt SHALL increment on each h_cnt wrap, wrapping from V_TOTAL-1 to 0, and SHALL load V_SYNC_START on a vsync falling edge, overriding any increment in the same cycle.
REQ-024 The period counter SHALL count clocks since the last hsync falling edge, saturating at 2047; at each hsync falling edge, line_len SHALL take the count and the counter SHALL restart at 1.
REQ-025 The line counter SHALL count hsync falling edges since the last vsync falling edge, saturating at 2047; at each vsync falling edge, frame_lines SHALL take the count and the counter SHALL restart at 0.
REQ-026 The FSM SHALL have states SEARCH, TRACK and LOCK.
REQ-027 In SEARCH, the first vsync falling edge SHALL move the FSM to TRACK with good_frames=0.
REQ-028 In TRACK, each vsync falling edge with a line count equal to V_TOTAL SHALL increment good_frames, and reaching LOCK_FRAMES SHALL move the FSM to LOCK.
REQ-029 In TRACK or LOCK, a violation SHALL pulse sync_err for 1 clk and move the FSM to SEARCH.
REQ-030 A violation SHALL be any of: an hsync falling edge with a period other than H_TOTAL, except the first edge after entering TRACK; a vsync falling edge with a line count other than V_TOTAL; or a period counter reaching 2*H_TOTAL (missing hsync).
REQ-031 In SEARCH, no violation SHALL be flagged.
REQ-032 Simultaneous hsync and vsync falling edges SHALL both be evaluated in the same cycle, producing a single sync_err pulse if either fails.
REQ-033 locked SHALL be 1 iff the FSM is in LOCK, and SHALL fall in the cycle sync_err pulses.
REQ-034 pix_de SHALL be locked AND pix_x<H_ACTIVE AND pix_y<V_ACTIVE.
REQ-035 pix_rgb SHALL pass through regardless of pix_de.

Reset
REQ-036 While rst_n=0, the block SHALL asynchronously set: FSM=SEARCH, all counters=0, pix_x=0, pix_y=0, pix_de=0, pix_rgb=0, locked=0, line_len=0, frame_lines=0, sync_err=0.
REQ-037 While rst_n=0, the registered hsync and vsync samples SHALL reset to 1, so no false edge is detected after release.
REQ-038 Reset asserted mid-frame SHALL abort tracking, and lock SHALL re-acquire only via SEARCH.

Verification
REQ-039 Ideal 800x525 timing (hsync low x=656..751, vsync low y=490..491) from reset -> locked=1 after the vsync edge starting the 3rd frame; line_len=800; frame_lines=525; sync_err never pulses.
REQ-040 While locked, drive the visible-area sample x=100, y=50 with rgb=3'b101 -> two clocks later pix_x=100, pix_y=50, pix_de=1, pix_rgb=3'b101.
REQ-041 While locked, shorten one line to 799 clocks -> sync_err pulses once, locked=0, line_len=799; lock returns after 2 further good frames.
REQ-042 While locked, hold hsync high for 1600 clocks -> sync_err pulses when the period counter reaches 1600, and the FSM returns to SEARCH.
REQ-043 Frame of 524 lines -> sync_err at the vsync edge; frame_lines=524.
REQ-044 Assert rst_n=0 mid-line while locked -> all outputs 0 immediately; after release, no sync_err and no lock before the first vsync edge.
